// File: rtl/locker_pkg.sv
// Shared keypad definitions: key codes, conditioner FSM encoding, keypad size.
// Imported by the key conditioner, the lock FSM and the display driver.
package locker_pkg;

  localparam int N_KEYS = 6;

  localparam logic [2:0] KEY_A    = 3'd0;
  localparam logic [2:0] KEY_B    = 3'd1;
  localparam logic [2:0] KEY_C    = 3'd2;
  localparam logic [2:0] KEY_D    = 3'd3;
  localparam logic [2:0] KEY_E    = 3'd4;
  localparam logic [2:0] KEY_F    = 3'd5;
  localparam logic [2:0] KEY_NONE = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

endpackage

// File: rtl/locker_debounce.sv
// One button: 2-FF synchroniser plus a counter that accepts a level only after DB_CYCLES stable cycles.
// Stable output follows a clean change DB_CYCLES+2 edges later; no flow control.
module locker_debounce #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic stable
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Any return to the accepted level restarts the count, so glitches never leak through.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/locker_key_conditioner.sv
// Keypad front-end: debounced buttons reduced to one KEY_VALID/KEY_MULTI pulse per press.
// KEY_VALID arrives DB_CYCLES+3 edges after a clean press; no backpressure, sample every cycle.
module locker_key_conditioner
  import locker_pkg::*;
#(
  parameter int N_BTN     = N_KEYS,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic             KEY_VALID,
  output logic [2:0]       KEY_CODE,
  output logic             KEY_MULTI,
  output logic [N_BTN-1:0] BTN_STABLE,
  output logic             BUSY
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    locker_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_db (
      .CLK    (CLK),
      .RST    (RST),
      .raw    (BTN_IN[i]),
      .stable (BTN_STABLE[i])
    );
  end

  logic [N_BTN-1:0] stable_d;
  logic [N_BTN-1:0] rise;
  logic             rise_multi;
  logic [2:0]       rise_code;
  state_t           state;

  assign rise       = BTN_STABLE & ~stable_d;
  // Clearing the lowest set bit leaves something only if two or more bits rose.
  assign rise_multi = |(rise & (rise - 1'b1));

  always_comb begin
    rise_code = KEY_NONE;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (rise[i]) rise_code = KEY_A + 3'(i);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stable_d  <= '0;
      state     <= ST_IDLE;
      KEY_VALID <= 1'b0;
      KEY_MULTI <= 1'b0;
      KEY_CODE  <= KEY_NONE;
      BUSY      <= 1'b0;
    end else begin
      stable_d  <= BTN_STABLE;
      KEY_VALID <= 1'b0;
      KEY_MULTI <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise_multi) begin
            KEY_MULTI <= 1'b1;
            state     <= ST_HELD;
            BUSY      <= 1'b1;
          end else if (|rise) begin
            KEY_VALID <= 1'b1;
            KEY_CODE  <= rise_code;
            state     <= ST_HELD;
            BUSY      <= 1'b1;
          end
        end
        ST_HELD: begin
          // Rollover presses are swallowed until the whole keypad is released.
          if (BTN_STABLE == '0) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_locker_key_conditioner.sv
// Directed bench for the keypad conditioner with DB_CYCLES=4; key events checked through a scoreboard queue.
module tb_locker_key_conditioner;

  localparam int N_BTN = 6;
  localparam int DB    = 4;
  localparam int LAT   = DB + 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [N_BTN-1:0] BTN_IN = '0;
  logic             KEY_VALID;
  logic [2:0]       KEY_CODE;
  logic             KEY_MULTI;
  logic [N_BTN-1:0] BTN_STABLE;
  logic             BUSY;

  locker_key_conditioner #(
    .N_BTN     (N_BTN),
    .DB_CYCLES (DB)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN_IN     (BTN_IN),
    .KEY_VALID  (KEY_VALID),
    .KEY_CODE   (KEY_CODE),
    .KEY_MULTI  (KEY_MULTI),
    .BTN_STABLE (BTN_STABLE),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       multi;
    logic [2:0] code;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic push_evt(input logic multi, input logic [2:0] code);
    exp_t e;
    e.multi = multi;
    e.code  = code;
    e.cyc   = cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic set_btn(input logic [N_BTN-1:0] v);
    @(negedge CLK);
    BTN_IN = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: every presented key event must match the oldest expectation.
  always @(negedge CLK) begin
    if (KEY_VALID || KEY_MULTI) begin
      check("valid_multi_exclusive", int'(KEY_VALID & KEY_MULTI), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("evt_is_multi", int'(KEY_MULTI), int'(e.multi));
        check("evt_code", int'(KEY_CODE), int'(e.code));
        check("evt_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    logic [N_BTN-1:0] seen_stable;
    logic             seen_busy;

    // Reset values
    #12;
    check("rst_valid", int'(KEY_VALID), 0);
    check("rst_multi", int'(KEY_MULTI), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_stable", int'(BTN_STABLE), 0);
    check("rst_code", int'(KEY_CODE), 7);
    @(negedge CLK);
    RST = 1'b1;
    wait_cyc(2);

    // 1: single press of A
    set_btn(6'b000001);
    push_evt(1'b0, 3'd0);
    wait_cyc(9);
    check("t1_stable_held", int'(BTN_STABLE), 1);
    check("t1_busy_held", int'(BUSY), 1);
    check("t1_code", int'(KEY_CODE), 0);
    set_btn('0);
    wait_cyc(4);
    check("t1_busy_until_release_debounced", int'(BUSY), 1);
    wait_cyc(6);
    check("t1_busy_released", int'(BUSY), 0);
    check("t1_stable_released", int'(BTN_STABLE), 0);

    // 2: A..F in turn
    for (int i = 0; i < N_BTN; i++) begin
      set_btn(N_BTN'(1 << i));
      push_evt(1'b0, 3'(i));
      wait_cyc(9);
      set_btn('0);
      wait_cyc(9);
    end
    check("t2_code_last", int'(KEY_CODE), 5);

    // 3: three-cycle glitch on C
    set_btn(6'b000100);
    wait_cyc(2);
    set_btn('0);
    seen_stable = '0;
    seen_busy   = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      seen_stable |= BTN_STABLE;
      seen_busy   |= BUSY;
    end
    check("t3_glitch_stable", int'(seen_stable), 0);
    check("t3_glitch_busy", int'(seen_busy), 0);

    // 4: A and E together
    set_btn(6'b010001);
    push_evt(1'b1, 3'd5);
    wait_cyc(9);
    check("t4_busy", int'(BUSY), 1);
    check("t4_code_kept", int'(KEY_CODE), 5);
    set_btn(6'b000001);
    wait_cyc(10);
    check("t4_busy_one_held", int'(BUSY), 1);
    set_btn('0);
    wait_cyc(10);
    check("t4_busy_released", int'(BUSY), 0);

    // 5: rollover B while A held, then C
    set_btn(6'b000001);
    push_evt(1'b0, 3'd0);
    wait_cyc(15);
    set_btn(6'b000011);
    wait_cyc(15);
    check("t5_stable_ab", int'(BTN_STABLE), 3);
    set_btn(6'b000001);
    wait_cyc(15);
    check("t5_code_still_a", int'(KEY_CODE), 0);
    set_btn('0);
    wait_cyc(15);
    check("t5_busy_released", int'(BUSY), 0);
    set_btn(6'b000100);
    push_evt(1'b0, 3'd2);
    wait_cyc(12);
    set_btn('0);
    wait_cyc(12);

    // 6: reset in the middle of a D press
    set_btn(6'b001000);
    push_evt(1'b0, 3'd3);
    wait_cyc(12);
    check("t6_busy_before_rst", int'(BUSY), 1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("t6_rst_valid", int'(KEY_VALID), 0);
    check("t6_rst_multi", int'(KEY_MULTI), 0);
    check("t6_rst_busy", int'(BUSY), 0);
    check("t6_rst_stable", int'(BTN_STABLE), 0);
    check("t6_rst_code", int'(KEY_CODE), 7);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    push_evt(1'b0, 3'd3);
    wait_cyc(12);
    check("t6_busy_after_rst", int'(BUSY), 1);
    set_btn('0);
    wait_cyc(12);
    check("t6_busy_released", int'(BUSY), 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
